// File: rtl/notification_transmitter_pkg.sv
// Shared types and constants for the notification transmitter: FSM encoding,
// source identifiers, frame header layout and drop counter limits.
package notification_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } tx_state_t;

  // Source slots, listed from highest to lowest priority
  localparam int NUM_SRC        = 3;
  localparam int SRC_IDX_ERROR  = 0;
  localparam int SRC_IDX_CONFIG = 1;
  localparam int SRC_IDX_VGA    = 2;

  localparam logic [1:0] SRC_CONFIG = 2'b01;
  localparam logic [1:0] SRC_ERROR  = 2'b10;
  localparam logic [1:0] SRC_VGA    = 2'b11;

  localparam logic [3:0] HDR_PREFIX = 4'b1010;

  localparam int                          DROP_COUNT_WIDTH = 4;
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT_MAX   = 4'd15;

  function automatic logic [1:0] src_code(input int idx);
    case (idx)
      SRC_IDX_ERROR:  return SRC_ERROR;
      SRC_IDX_CONFIG: return SRC_CONFIG;
      default:        return SRC_VGA;
    endcase
  endfunction

  function automatic logic [7:0] header_byte(input logic [1:0] src);
    return {HDR_PREFIX, 2'b00, src};
  endfunction

endpackage

// File: rtl/notification_arbiter.sv
// Per-source pending flags and code registers, fixed-priority selection
// (error > config > VGA) and a saturating counter of overwritten messages.
module notification_arbiter
  import notification_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH                = 8,
  parameter int CONFIG_NOTIFICATION_WIDTH = 4,
  parameter int CONFIG_ERROR_WIDTH        = 4,
  parameter int VGA_NOTIFICATION_WIDTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] config_notification,
  input  logic                                 config_notification_valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        config_error,
  input  logic                                 error_valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    vga_notification,
  input  logic                                 vga_notification_valid,
  input  logic                                 take,
  output logic                                 any_pending,
  output logic [1:0]                           sel_src,
  output logic [DATA_WIDTH-1:0]                sel_code,
  output logic [DROP_COUNT_WIDTH-1:0]          drop_count
);

  logic [NUM_SRC-1:0]        valid_vec;
  logic [NUM_SRC-1:0]        pending_vec;
  logic [NUM_SRC-1:0]        grant;
  logic [NUM_SRC-1:0]        drop_vec;
  logic [DATA_WIDTH-1:0]     code_in  [NUM_SRC];
  logic [DATA_WIDTH-1:0]     code_vec [NUM_SRC];
  logic [DROP_COUNT_WIDTH-1:0] drop_count_reg;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_next;
  logic [DROP_COUNT_WIDTH:0]   drop_sum;

  assign valid_vec = {vga_notification_valid, config_notification_valid, error_valid};

  assign code_in[SRC_IDX_ERROR]  = DATA_WIDTH'(config_error);
  assign code_in[SRC_IDX_CONFIG] = DATA_WIDTH'(config_notification);
  assign code_in[SRC_IDX_VGA]    = DATA_WIDTH'(vga_notification);

  // Lowest index wins: isolate the lowest set pending bit
  assign grant       = pending_vec & (~pending_vec + NUM_SRC'(1));
  assign any_pending = |pending_vec;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic                  pending_reg;
      logic [DATA_WIDTH-1:0] code_reg;

      // A message consumed on this very edge is not lost, so no drop then
      assign drop_vec[gi]    = valid_vec[gi] & pending_reg & ~(take & grant[gi]);
      assign pending_vec[gi] = pending_reg;
      assign code_vec[gi]    = code_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg <= 1'b0;
          code_reg    <= '0;
        end else if (valid_vec[gi]) begin
          pending_reg <= 1'b1;
          code_reg    <= code_in[gi];
        end else if (take && grant[gi]) begin
          pending_reg <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    sel_src  = '0;
    sel_code = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_src  = src_code(i);
        sel_code = code_vec[i];
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_count_reg} + (DROP_COUNT_WIDTH+1)'($countones(drop_vec));
    if (drop_sum > {1'b0, DROP_COUNT_MAX}) begin
      drop_count_next = DROP_COUNT_MAX;
    end else begin
      drop_count_next = drop_sum[DROP_COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
    end else begin
      drop_count_reg <= drop_count_next;
    end
  end

  assign drop_count = drop_count_reg;

endmodule

// File: rtl/notification_transmitter.sv
// Frames pending notifications as header/payload/checksum bytes and writes
// them into a TX FIFO, stalling while the FIFO reports full.
module notification_transmitter
  import notification_transmitter_pkg::*;
#(
  parameter int UART_DATA_WIDTH           = 8,
  parameter int CONFIG_NOTIFICATION_WIDTH = 4,
  parameter int CONFIG_ERROR_WIDTH        = 4,
  parameter int VGA_NOTIFICATION_WIDTH    = 4
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  input  logic                                 VGA_Notification_Valid,
  input  logic                                 Full,
  output logic [UART_DATA_WIDTH-1:0]           TXD_Data,
  output logic                                 Wr_En,
  output logic                                 Busy,
  output logic [DROP_COUNT_WIDTH-1:0]          Drop_Count
);

  tx_state_t                  state_reg;
  tx_state_t                  state_next;
  logic [1:0]                 shadow_src_reg;
  logic [UART_DATA_WIDTH-1:0] shadow_code_reg;
  logic                       take;
  logic                       any_pending;
  logic [1:0]                 sel_src;
  logic [UART_DATA_WIDTH-1:0] sel_code;
  logic [UART_DATA_WIDTH-1:0] hdr_byte;
  logic [UART_DATA_WIDTH-1:0] chk_byte;

  notification_arbiter #(
    .DATA_WIDTH               (UART_DATA_WIDTH),
    .CONFIG_NOTIFICATION_WIDTH(CONFIG_NOTIFICATION_WIDTH),
    .CONFIG_ERROR_WIDTH       (CONFIG_ERROR_WIDTH),
    .VGA_NOTIFICATION_WIDTH   (VGA_NOTIFICATION_WIDTH)
  ) u_arbiter (
    .clk                      (Clk),
    .rst_n                    (Rst),
    .config_notification      (Config_Notification),
    .config_notification_valid(Config_Notification_Valid),
    .config_error             (Config_Error),
    .error_valid              (Error_Valid),
    .vga_notification         (VGA_Notification),
    .vga_notification_valid   (VGA_Notification_Valid),
    .take                     (take),
    .any_pending              (any_pending),
    .sel_src                  (sel_src),
    .sel_code                 (sel_code),
    .drop_count               (Drop_Count)
  );

  assign take     = (state_reg == IDLE) && any_pending;
  assign hdr_byte = UART_DATA_WIDTH'(header_byte(shadow_src_reg));
  assign chk_byte = hdr_byte ^ shadow_code_reg;
  assign Busy     = (state_reg != IDLE) || any_pending;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg       <= IDLE;
      shadow_src_reg  <= '0;
      shadow_code_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        shadow_src_reg  <= sel_src;
        shadow_code_reg <= sel_code;
      end
    end
  end

  // Each frame byte is held until the FIFO accepts it
  always_comb begin
    state_next = state_reg;
    TXD_Data   = '0;
    Wr_En      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_pending) state_next = HDR;
      end
      HDR: begin
        TXD_Data = hdr_byte;
        Wr_En    = !Full;
        if (!Full) state_next = PAY;
      end
      PAY: begin
        TXD_Data = shadow_code_reg;
        Wr_En    = !Full;
        if (!Full) state_next = CHK;
      end
      CHK: begin
        TXD_Data = chk_byte;
        Wr_En    = !Full;
        if (!Full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_notification_transmitter.sv
// Self-checking bench: vector table plus hand-written sequences, with a byte
// scoreboard that checks every FIFO write against the expected frame stream.
module tb_notification_transmitter;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] Config_Notification = '0;
  logic       Config_Notification_Valid = 1'b0;
  logic [3:0] Config_Error = '0;
  logic       Error_Valid = 1'b0;
  logic [3:0] VGA_Notification = '0;
  logic       VGA_Notification_Valid = 1'b0;
  logic       Full = 1'b0;
  logic [7:0] TXD_Data;
  logic       Wr_En;
  logic       Busy;
  logic [3:0] Drop_Count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 Clk = ~Clk;

  notification_transmitter dut (
    .Clk                      (Clk),
    .Rst                      (Rst),
    .Config_Notification      (Config_Notification),
    .Config_Notification_Valid(Config_Notification_Valid),
    .Config_Error             (Config_Error),
    .Error_Valid              (Error_Valid),
    .VGA_Notification         (VGA_Notification),
    .VGA_Notification_Valid   (VGA_Notification_Valid),
    .Full                     (Full),
    .TXD_Data                 (TXD_Data),
    .Wr_En                    (Wr_En),
    .Busy                     (Busy),
    .Drop_Count               (Drop_Count)
  );

  // v = {error, config, vga}; stream holds expected bytes, first byte in the MSBs
  typedef struct packed {
    logic [2:0]  v;
    logic [3:0]  err;
    logic [3:0]  cfg;
    logic [3:0]  vga;
    logic [3:0]  nbytes;
    logic [71:0] stream;
  } vec_t;

  vec_t vecs[8];
  vec_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted FIFO write must match the next queued byte
  always @(negedge Clk) begin
    if (Rst === 1'b1 && Wr_En === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected no write at %0t", TXD_Data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_byte", {24'h0, TXD_Data}, {24'h0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] v, input logic [3:0] e, input logic [3:0] c,
                        input logic [3:0] g);
    tick();
    Config_Error              = e;
    Config_Notification       = c;
    VGA_Notification          = g;
    Error_Valid               = v[2];
    Config_Notification_Valid = v[1];
    VGA_Notification_Valid    = v[0];
    tick();
    Error_Valid               = 1'b0;
    Config_Notification_Valid = 1'b0;
    VGA_Notification_Valid    = 1'b0;
  endtask

  task automatic push3(input logic [23:0] s);
    exp_q.push_back(s[23:16]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("idle_reached", {31'h0, Busy}, 32'h0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic expect_wr(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check($sformatf("wr_en_cycle%0d", i), {31'h0, Wr_En}, {31'h0, pat[i]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{v:3'b010, err:4'h0, cfg:4'h5, vga:4'h0, nbytes:4'd3, stream:{24'hA105A4, 48'h0}};
    vecs[1] = '{v:3'b100, err:4'h3, cfg:4'h0, vga:4'h0, nbytes:4'd3, stream:{24'hA203A1, 48'h0}};
    vecs[2] = '{v:3'b001, err:4'h0, cfg:4'h0, vga:4'h9, nbytes:4'd3, stream:{24'hA309AA, 48'h0}};
    vecs[3] = '{v:3'b010, err:4'h0, cfg:4'hF, vga:4'h0, nbytes:4'd3, stream:{24'hA10FAE, 48'h0}};
    vecs[4] = '{v:3'b100, err:4'h0, cfg:4'h0, vga:4'h0, nbytes:4'd3, stream:{24'hA200A2, 48'h0}};
    vecs[5] = '{v:3'b001, err:4'h0, cfg:4'h0, vga:4'hC, nbytes:4'd3, stream:{24'hA30CAF, 48'h0}};
    vecs[6] = '{v:3'b101, err:4'h3, cfg:4'h0, vga:4'h9, nbytes:4'd6, stream:{48'hA203A1A309AA, 24'h0}};
    vecs[7] = '{v:3'b111, err:4'h7, cfg:4'h5, vga:4'h9, nbytes:4'd9, stream:72'hA207A5A105A4A309AA};

    // Reset values
    #2;
    check("rst_wr_en", {31'h0, Wr_En}, 32'h0);
    check("rst_txd", {24'h0, TXD_Data}, 32'h0);
    check("rst_busy", {31'h0, Busy}, 32'h0);
    check("rst_drop", {28'h0, Drop_Count}, 32'h0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cur = vecs[i];
      for (int j = 0; j < int'(cur.nbytes); j++) exp_q.push_back(cur.stream[71-8*j -: 8]);
      strobe(cur.v, cur.err, cur.cfg, cur.vga);
      wait_idle();
      check($sformatf("vec%0d_drop", i), {28'h0, Drop_Count}, 32'h0);
    end

    // Latency: header in 2nd cycle after sampling edge, three consecutive writes
    push3(24'hA105A4);
    strobe(3'b010, 4'h0, 4'h5, 4'h0);
    expect_wr(16'h000E, 5);
    wait_idle();

    // Two frames back to back with exactly one idle cycle between them
    push3(24'hA203A1);
    push3(24'hA309AA);
    strobe(3'b101, 4'h3, 4'h0, 4'h9);
    expect_wr(16'h00EE, 9);
    wait_idle();

    // FIFO full for 5 cycles while the payload is presented
    push3(24'hA105A4);
    strobe(3'b010, 4'h0, 4'h5, 4'h0);
    @(negedge Clk);
    check("full_pre_wr", {31'h0, Wr_En}, 32'h0);
    tick();
    @(negedge Clk);
    check("full_hdr_txd", {24'h0, TXD_Data}, 32'hA1);
    tick();
    Full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("full_hold_wr", {31'h0, Wr_En}, 32'h0);
      check("full_hold_txd", {24'h0, TXD_Data}, 32'h05);
      tick();
    end
    Full = 1'b0;
    expect_wr(16'h0003, 3);
    wait_idle();

    // Same source re-strobed while its frame is in flight: resend, no drop
    push3(24'hA105A4);
    strobe(3'b010, 4'h0, 4'h5, 4'h0);
    push3(24'hA106A7);
    strobe(3'b010, 4'h0, 4'h6, 4'h0);
    wait_idle();
    check("inflight_no_drop", {28'h0, Drop_Count}, 32'h0);

    // Two VGA strobes during an error frame: second overwrites the first
    push3(24'hA203A1);
    strobe(3'b100, 4'h3, 4'h0, 4'h0);
    push3(24'hA302A1);
    strobe(3'b001, 4'h0, 4'h0, 4'h1);
    strobe(3'b001, 4'h0, 4'h0, 4'h2);
    check("overwrite_drop", {28'h0, Drop_Count}, 32'h1);
    wait_idle();

    // Saturation: 17 overwrites of a pending VGA code while the link is stalled
    tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check("sat_start_drop", {28'h0, Drop_Count}, 32'h0);
    Full = 1'b1;
    push3(24'hA101A0);
    strobe(3'b010, 4'h0, 4'h1, 4'h0);
    for (int i = 0; i < 18; i++) begin
      logic [4:0] idx;
      idx = 5'(i);
      strobe(3'b001, 4'h0, 4'h0, idx[3:0]);
      if (i == 5) check("sat_mid_drop", {28'h0, Drop_Count}, 32'h5);
    end
    check("sat_busy", {31'h0, Busy}, 32'h1);
    check("sat_drop", {28'h0, Drop_Count}, 32'hF);
    push3(24'hA301A2);
    Full = 1'b0;
    wait_idle();

    // Reset during CHK: frame abandoned immediately, strobes under reset ignored
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h05);
    strobe(3'b010, 4'h0, 4'h5, 4'h0);
    tick();
    tick();
    tick();
    check("chk_txd", {24'h0, TXD_Data}, 32'hA4);
    Rst = 1'b0;
    #1;
    check("mid_rst_wr_en", {31'h0, Wr_En}, 32'h0);
    check("mid_rst_busy", {31'h0, Busy}, 32'h0);
    check("mid_rst_drop", {28'h0, Drop_Count}, 32'h0);
    check("mid_rst_txd", {24'h0, TXD_Data}, 32'h0);
    strobe(3'b111, 4'h1, 4'h2, 4'h3);
    Rst = 1'b1;
    repeat (10) tick();
    check("post_rst_busy", {31'h0, Busy}, 32'h0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
